// File: rtl/hdmi_fb_reader.sv
// Frame-buffer reader: fetches a frame with Avalon-MM bursts into a show-ahead FIFO that feeds an HDMI pixel stream.
// Optional build macro HDMI_FB_UNDERFLOW_EN enables the sticky underflow detector.
module hdmi_fb_reader #(
  parameter int H_PIX      = 1024,
  parameter int V_PIX      = 600,
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] base_addr,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [7:0]  avm_burstcount,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [23:0] st_data,
  output logic        st_valid,
  input  logic        st_ready,
  output logic        st_sof,
  output logic        busy,
  output logic        underflow,
  output logic [1:0]  dbg_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = CW + 2;
  localparam logic [31:0] TOTAL       = 32'(H_PIX * V_PIX);
  localparam logic [31:0] BURST_W     = 32'(BURST);
  localparam logic [31:0] BURST_BYTES = 32'(BURST * 4);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, REQ = 2'd2, FRAME_END = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [31:0]   ptr_q, ptr_d;
  logic [31:0]   wcnt_q, wcnt_d;
  logic [31:0]   rxcnt_q, rxcnt_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [24:0]   mem_q [FIFO_DEPTH];
  logic [FW-1:0] fill_sum;
  logic          room, req_done, push, pop;
  logic          unused_readdata;

  assign unused_readdata = ^avm_readdata[31:24];

  // Space is reserved for words already requested so a returning burst can never overflow the FIFO.
  assign fill_sum = {2'b00, count_q} + {2'b00, outst_q} + FW'(BURST);
  assign room     = (fill_sum <= FW'(FIFO_DEPTH));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wcnt_d   = wcnt_q;
    req_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = ARM;
          ptr_d   = base_addr;
          wcnt_d  = '0;
        end
      end
      ARM: begin
        if (room) state_d = REQ;
      end
      REQ: begin
        if (!avm_waitrequest) begin
          req_done = 1'b1;
          ptr_d    = ptr_q + BURST_BYTES;
          wcnt_d   = wcnt_q + BURST_W;
          state_d  = (wcnt_q + BURST_W == TOTAL) ? FRAME_END : ARM;
        end
      end
      FRAME_END: begin
        if (run) begin
          state_d = ARM;
          ptr_d   = base_addr;
          wcnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign st_valid = (count_q != '0);
  assign push     = avm_readdatavalid && (outst_q != '0);
  assign pop      = st_valid && st_ready;

  // The first-of-frame tag follows the received word count, so it stays correct even
  // when the next frame's requests start before the previous frame's data has drained.
  always_comb begin
    outst_d  = outst_q;
    count_d  = count_q;
    rxcnt_d  = rxcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (req_done) outst_d = outst_d + CW'(BURST);
    if (push) begin
      outst_d  = outst_d - CW'(1);
      wr_ptr_d = wr_ptr_q + AW'(1);
      rxcnt_d  = (rxcnt_q == TOTAL - 32'd1) ? '0 : rxcnt_q + 32'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      wcnt_q   <= '0;
      rxcnt_q  <= '0;
      outst_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wcnt_q   <= wcnt_d;
      rxcnt_q  <= rxcnt_d;
      outst_q  <= outst_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {(rxcnt_q == '0), avm_readdata[23:0]};
  end

  assign st_data        = st_valid ? mem_q[rd_ptr_q][23:0] : '0;
  assign st_sof         = st_valid && mem_q[rd_ptr_q][24];
  assign avm_read       = (state_q == REQ);
  assign avm_address    = ptr_q;
  assign avm_burstcount = 8'(BURST);
  assign busy           = (state_q != IDLE) || st_valid;
  assign dbg_state      = state_q;

`ifdef HDMI_FB_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  always_comb begin
    underflow_d = underflow_q | (st_ready && !st_valid && (state_q != IDLE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) underflow_q <= 1'b0;
    else        underflow_q <= underflow_d;
  end

  assign underflow = underflow_q;
`else
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_hdmi_fb_reader.sv
// Bench for hdmi_fb_reader: table of single-frame vectors plus hand-written backpressure, run-drop, reset and underflow sequences.
module tb_hdmi_fb_reader;
  localparam int H_PIX = 8, V_PIX = 2, BURST = 4, FIFO_DEPTH = 8;
  localparam int NPIX = H_PIX * V_PIX;
  localparam int NBURST = NPIX / BURST;
`ifdef HDMI_FB_UNDERFLOW_EN
  localparam logic UF_EXP = 1'b1;
`else
  localparam logic UF_EXP = 1'b0;
`endif

  logic        clk, reset, run, st_ready;
  logic [31:0] base_addr;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic [31:0] avm_address;
  logic        avm_read, st_valid, st_sof, busy, underflow;
  logic [7:0]  avm_burstcount;
  logic [23:0] st_data;
  logic [1:0]  dbg_state;

  hdmi_fb_reader #(.H_PIX(H_PIX), .V_PIX(V_PIX), .BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .run(run), .base_addr(base_addr),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_sof(st_sof), .busy(busy), .underflow(underflow),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [24:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] rdq[$];
  int n_checks = 0, n_pass = 0;
  int n_bursts, n_words, frame_words, req_len, first_req_len, stall_left, data_budget;
  logic [31:0] held_addr, last_addr;
  logic [23:0] first_px, last_px;
  bit got_px, first_sent;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [23:0] pix(input logic [31:0] a);
    logic [23:0] lo;
    lo = a[23:0];
    return lo ^ 24'hC0FFEE;
  endfunction

  task automatic new_frame(input logic [31:0] base);
    n_bursts = 0; frame_words = 0; got_px = 0; first_req_len = 0;
    for (int i = 0; i < NPIX; i++) exp_q.push_back({(i == 0), pix(base + 32'(4 * i))});
    for (int b = 0; b < NBURST; b++) exp_addr_q.push_back(base + 32'(16 * b));
    base_addr = base;
  endtask

  // Memory slave and stream monitor, sampling 1 time unit after the falling edge.
  initial begin : mem_model
    logic [24:0] e;
    logic [31:0] a;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        if (first_sent) begin
          check("latency_valid", st_valid, 1);
          check("latency_sof", st_sof, 1);
          first_sent = 0;
        end
        if (st_valid && st_ready) begin
          check("pop_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("st_data", st_data, e[23:0]);
            check("st_sof", st_sof, e[24]);
            check("busy_while_valid", busy, 1);
            if (!got_px) first_px = st_data;
            got_px = 1; last_px = st_data;
          end
        end
      end
      if (rdq.size() != 0 && data_budget != 0) begin
        a = rdq.pop_front();
        avm_readdatavalid = 1'b1; avm_readdata = {8'hAB, pix(a)};
        if (data_budget > 0) data_budget--;
        if (frame_words == 0) first_sent = 1;
        frame_words++; n_words++;
      end else begin
        avm_readdatavalid = 1'b0; avm_readdata = '0;
      end
      if (!reset) begin
        avm_waitrequest = 1'b0; req_len = 0;
      end else if (avm_read) begin
        if (req_len != 0) check("addr_hold", avm_address, held_addr);
        held_addr = avm_address;
        req_len++;
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1; stall_left--;
        end else begin
          avm_waitrequest = 1'b0;
          check("burstcount", avm_burstcount, BURST);
          check("burst_expected", exp_addr_q.size() != 0, 1);
          if (exp_addr_q.size() != 0) check("burst_addr", avm_address, exp_addr_q.pop_front());
          for (int i = 0; i < BURST; i++) rdq.push_back(avm_address + 32'(4 * i));
          if (n_bursts == 0) first_req_len = req_len;
          last_addr = avm_address; n_bursts++; req_len = 0;
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic wait_done(input int mode, input int budget);
    int cyc = 0;
    bit done = 0;
    while (!done && cyc < budget) begin
      @(negedge clk); cyc++;
      st_ready = (mode == 1) ? cyc[0] : 1'b1;
      #2;
      if (exp_q.size() == 0 && exp_addr_q.size() == 0 && !busy && dbg_state == 2'd0) done = 1;
    end
    check("frame_done", done, 1);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  typedef struct {
    logic [31:0] base;
    int          ready_mode;
    int          stall;
    logic [31:0] exp_last_addr;
    logic [23:0] exp_first_px;
    logic [23:0] exp_last_px;
    int          exp_req_len;
  } vec_t;

  vec_t vecs[3];

  initial begin : test
    int cyc, w0;
    vecs[0] = '{32'h0000_1000, 0, 0, 32'h0000_1030, 24'hC0EFEE, 24'hC0EFD2, 1};
    vecs[1] = '{32'h00AB_CDE0, 1, 0, 32'h00AB_CE10, 24'h6B320E, 24'h6B31F2, 1};
    vecs[2] = '{32'hFFFF_FFE0, 1, 5, 32'h0000_0010, 24'h3F000E, 24'hC0FFF2, 6};

    reset = 1'b0; run = 1'b0; st_ready = 1'b0; base_addr = '0;
    stall_left = 0; data_budget = -1; n_words = 0; first_sent = 0;
    n_bursts = 0; frame_words = 0; got_px = 0; req_len = 0;
    #2;
    check("rst_avm_read", avm_read, 0);
    check("rst_avm_address", avm_address, 0);
    check("rst_st_valid", st_valid, 0);
    check("rst_st_data", st_data, 0);
    check("rst_st_sof", st_sof, 0);
    check("rst_busy", busy, 0);
    check("rst_underflow", underflow, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk); @(negedge clk); reset = 1'b1;

    for (int v = 0; v < 3; v++) begin
      new_frame(vecs[v].base);
      stall_left = vecs[v].stall;
      @(negedge clk);
      pulse_run();
      wait_done(vecs[v].ready_mode, 600);
      check("vec_bursts", n_bursts, NBURST);
      check("vec_last_addr", last_addr, vecs[v].exp_last_addr);
      check("vec_first_px", first_px, vecs[v].exp_first_px);
      check("vec_last_px", last_px, vecs[v].exp_last_px);
      check("vec_req_len", first_req_len, vecs[v].exp_req_len);
      check("vec_idle", dbg_state, 0);
    end

    // sink stalled with run held: FIFO fills, requests stop, stream resumes in order
    new_frame(32'h0000_2000);
    @(negedge clk); st_ready = 1'b0; run = 1'b1;
    repeat (100) @(negedge clk);
    #2;
    check("bp_bursts", n_bursts, FIFO_DEPTH / BURST);
    check("bp_words", frame_words, FIFO_DEPTH);
    check("bp_no_read", avm_read, 0);
    check("bp_state_arm", dbg_state, 1);
    check("bp_head_data", st_data, pix(32'h0000_2000));
    check("bp_head_sof", st_sof, 1);
    run = 1'b0;
    wait_done(0, 600);
    check("bp_total_bursts", n_bursts, NBURST);

    // run dropped after the second burst: the frame still completes
    new_frame(32'h0000_5000);
    @(negedge clk); st_ready = 1'b1; run = 1'b1;
    cyc = 0;
    while (n_bursts < 2 && cyc < 200) begin
      @(negedge clk); cyc++; #2;
    end
    check("rd_two_bursts", n_bursts >= 2, 1);
    run = 1'b0;
    wait_done(0, 600);
    check("rd_all_bursts", n_bursts, NBURST);
    check("rd_busy_low", busy, 0);
    repeat (20) @(negedge clk);
    #2;
    check("rd_no_more_bursts", n_bursts, NBURST);
    check("rd_no_read", avm_read, 0);

    // memory stalled while the sink is ready
    pulse_reset();
    #2;
    check("uf_clear", underflow, 0);
    new_frame(32'h0000_4000);
    data_budget = 0; st_ready = 1'b1;
    @(negedge clk);
    pulse_run();
    repeat (10) @(negedge clk);
    #2;
    check("uf_set", underflow, UF_EXP);
    check("uf_stalled_empty", st_valid, 0);
    data_budget = -1;
    wait_done(0, 600);
    check("uf_sticky", underflow, UF_EXP);
    pulse_reset();
    #2;
    check("uf_reset", underflow, 0);

    // reset while a burst is still returning data
    new_frame(32'h0000_3000);
    st_ready = 1'b0; data_budget = 1;
    @(negedge clk);
    pulse_run();
    cyc = 0;
    while (frame_words < 1 && cyc < 100) begin
      @(negedge clk); cyc++; #2;
    end
    check("rst_word_sent", frame_words, 1);
    @(negedge clk); #2;
    check("rst_pre_valid", st_valid, 1);
    check("rst_inflight", rdq.size() >= 3, 1);
    @(negedge clk); reset = 1'b0;
    #2;
    check("mid_rst_avm_read", avm_read, 0);
    check("mid_rst_avm_address", avm_address, 0);
    check("mid_rst_st_valid", st_valid, 0);
    check("mid_rst_st_data", st_data, 0);
    check("mid_rst_st_sof", st_sof, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", dbg_state, 0);
    exp_q.delete(); exp_addr_q.delete();
    @(negedge clk); reset = 1'b1; data_budget = 3; w0 = n_words;
    repeat (10) begin
      @(negedge clk); #2;
      check("late_strobe_empty", st_valid, 0);
    end
    check("late_strobes_sent", n_words - w0, 3);
    check("late_busy", busy, 0);
    check("late_state", dbg_state, 0);
    rdq.delete(); data_budget = -1;

    check("final_underflow", underflow, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
